uart_bus_if: RTL and testbench

CPU-side register interface for the UART datapath. It sits upstream of the transmitter FIFO and downstream of the receiver FIFO.
- Converts simple single-cycle bus accesses into FIFO push/pop pulses.
- Generates the receiver-FIFO write strobe from rx_done.
- Synchronises and latches receiver error flags into sticky registers.
- Drives a level interrupt.

---
 rtl/uart_bus_if.sv | 168 ++++++++++++++++
 tb/tb_uart_bus_if.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_if.sv
// -----------------------------------------------------------------------------
// uart_bus_if
//
// CPU-side register interface for the UART datapath. It turns single-cycle bus
// accesses into TX/RX FIFO push/pop pulses. It turns the receiver's
// frame-complete level into an RX FIFO write strobe. It collects receiver and
// bus error conditions in a sticky ERROR register, and drives a level
// interrupt.
//
// Register map (bus_addr):
//   0 DATA    write pushes into the TX FIFO, read pops the RX FIFO
//   1 STATUS  {rx_full, rx_empty, tx_full, tx_empty}, read-only
//   2 ERROR   {rx_drop, rx_underrun, tx_overrun, overflow, break, stop,
//             parity}, sticky, write-1-to-clear
//   3 IRQ_EN  {error, tx_empty, rx_not_empty} interrupt enables
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   bus_sel/bus_write    one-cycle access strobe and direction
//   bus_addr/bus_wdata   register select and write data
//   bus_rdata/bus_rvalid registered read data, valid for one cycle
//   bus_data_in          TX FIFO data, with write_data as its push pulse
//   tx_full/tx_empty     TX FIFO flags
//   bus_data_out         RX FIFO head word, with read_data as its pop pulse
//   rx_full/rx_empty     RX FIFO flags
//   rx_done, *_error     receiver levels from the sample clock origin
//   rx_fifo_write        RX FIFO push pulse, one per received frame
//   irq                  registered interrupt request
// -----------------------------------------------------------------------------
module uart_bus_if #(
  parameter int DATA_SIZE   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bus_sel,
  input  logic                 bus_write,
  input  logic [1:0]           bus_addr,
  input  logic [DATA_SIZE-1:0] bus_wdata,
  output logic [DATA_SIZE-1:0] bus_rdata,
  output logic                 bus_rvalid,
  output logic [DATA_SIZE-1:0] bus_data_in,
  output logic                 write_data,
  input  logic                 tx_full,
  input  logic                 tx_empty,
  input  logic [DATA_SIZE-1:0] bus_data_out,
  output logic                 read_data,
  input  logic                 rx_full,
  input  logic                 rx_empty,
  input  logic                 rx_done,
  input  logic                 parity_error,
  input  logic                 stop_error,
  input  logic                 break_error,
  input  logic                 overflow_error,
  output logic                 rx_fifo_write,
  output logic                 irq
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_ERROR  = 2'd2;

  // Synchroniser chains: stage 0 samples the raw input, the last stage is the
  // synchronised level used by the rest of the block.
  logic [SYNC_STAGES-1:0] done_sync;
  logic                   done_prev;
  logic [3:0]             err_sync [SYNC_STAGES];

  logic [6:0]             err_reg;
  logic [2:0]             irq_en;

  logic                   rd_acc;
  logic                   wr_acc;
  logic                   tx_push;
  logic                   rx_pop;
  logic                   frame_evt;
  logic [6:0]             err_set;
  logic [6:0]             err_clr;
  logic [6:0]             err_next;
  logic [DATA_SIZE-1:0]   read_mux;

  // Access decode, sticky-error update and read-data selection. Sets are OR'd
  // in after the W1C mask, so a set and a clear on the same bit in the same
  // cycle leave the bit set.
  always_comb begin
    rd_acc    = bus_sel & ~bus_write;
    wr_acc    = bus_sel & bus_write;
    tx_push   = wr_acc & (bus_addr == ADDR_DATA) & ~tx_full;
    rx_pop    = rd_acc & (bus_addr == ADDR_DATA) & ~rx_empty;
    // A frame is the rising edge of the synchronised rx_done level, so a level
    // held high counts once and a new frame needs a low cycle in between.
    frame_evt = done_sync[SYNC_STAGES-1] & ~done_prev;

    err_set = '0;
    if (frame_evt) begin
      err_set[3:0] = err_sync[SYNC_STAGES-1];
      err_set[6]   = rx_full;
    end
    err_set[4] = wr_acc & (bus_addr == ADDR_DATA) & tx_full;
    err_set[5] = rd_acc & (bus_addr == ADDR_DATA) & rx_empty;

    err_clr  = (wr_acc && (bus_addr == ADDR_ERROR)) ? bus_wdata[6:0] : '0;
    err_next = (err_reg & ~err_clr) | err_set;

    read_mux = '0;
    case (bus_addr)
      ADDR_DATA:   read_mux = rx_empty ? '0 : bus_data_out;
      ADDR_STATUS: read_mux = DATA_SIZE'({rx_full, rx_empty, tx_full, tx_empty});
      ADDR_ERROR:  read_mux = DATA_SIZE'(err_reg);
      default:     read_mux = DATA_SIZE'(irq_en);
    endcase
  end

  // Receiver-side synchronisers plus the delayed copy used for edge detection.
  // rx_done and the error levels go through equal-depth chains, so the error
  // levels that are OR'd in line up with the frame they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_sync <= '0;
      done_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        err_sync[i] <= '0;
      end
    end else begin
      done_sync   <= {done_sync[SYNC_STAGES-2:0], rx_done};
      done_prev   <= done_sync[SYNC_STAGES-1];
      err_sync[0] <= {overflow_error, break_error, stop_error, parity_error};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        err_sync[i] <= err_sync[i-1];
      end
    end
  end

  // Registered bus outputs, FIFO strobes, register state and interrupt. Every
  // strobe is recomputed each cycle, so none can stretch past one cycle. The
  // interrupt uses the register values from before this cycle's update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_rdata     <= '0;
      bus_rvalid    <= 1'b0;
      bus_data_in   <= '0;
      write_data    <= 1'b0;
      read_data     <= 1'b0;
      rx_fifo_write <= 1'b0;
      err_reg       <= '0;
      irq_en        <= '0;
      irq           <= 1'b0;
    end else begin
      bus_rvalid    <= rd_acc;
      write_data    <= tx_push;
      read_data     <= rx_pop;
      rx_fifo_write <= frame_evt & ~rx_full;
      err_reg       <= err_next;
      irq           <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty) |
                       (irq_en[2] & (|err_reg));
      if (rd_acc) begin
        bus_rdata <= read_mux;
      end
      if (tx_push) begin
        bus_data_in <= bus_wdata;
      end
      if (wr_acc && (bus_addr == 2'd3)) begin
        irq_en <= bus_wdata[2:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_if.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_if
//
// Self-checking bench for uart_bus_if. The bench has four parts:
//   - checks of the reset state;
//   - a table of single bus accesses with constant expected outputs;
//   - hand-written sequences for the multi-cycle cases: overrun and underrun,
//     frame detection and its latency, sticky error priority, the interrupt
//     and reset in the middle of an access;
//   - randomized traffic compared against a cycle-level reference model built
//     from the register-map rules.
// -----------------------------------------------------------------------------
module tb_uart_bus_if;

  localparam int DW   = 8;
  localparam int SYNC = 2;

  logic          clk;
  logic          reset_n;
  logic          bus_sel;
  logic          bus_write;
  logic [1:0]    bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_rvalid;
  logic [DW-1:0] bus_data_in;
  logic          write_data;
  logic          tx_full;
  logic          tx_empty;
  logic [DW-1:0] bus_data_out;
  logic          read_data;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_done;
  logic          parity_error;
  logic          stop_error;
  logic          break_error;
  logic          overflow_error;
  logic          rx_fifo_write;
  logic          irq;

  int checks;
  int errors;

  uart_bus_if #(.DATA_SIZE(DW), .SYNC_STAGES(SYNC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus_sel        (bus_sel),
    .bus_write      (bus_write),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_rvalid     (bus_rvalid),
    .bus_data_in    (bus_data_in),
    .write_data     (write_data),
    .tx_full        (tx_full),
    .tx_empty       (tx_empty),
    .bus_data_out   (bus_data_out),
    .read_data      (read_data),
    .rx_full        (rx_full),
    .rx_empty       (rx_empty),
    .rx_done        (rx_done),
    .parity_error   (parity_error),
    .stop_error     (stop_error),
    .break_error    (break_error),
    .overflow_error (overflow_error),
    .rx_fifo_write  (rx_fifo_write),
    .irq            (irq)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row: a single bus access with FIFO flags, and the expected
  // outputs one cycle later.
  typedef struct {
    logic          sel;
    logic          write;
    logic [1:0]    addr;
    logic [DW-1:0] wdata;
    logic [3:0]    stat;
    logic [DW-1:0] dout;
    logic          exp_rvalid;
    logic [DW-1:0] exp_rdata;
    logic          exp_wr;
    logic [DW-1:0] exp_din;
    logic          exp_rd;
  } vec_t;

  vec_t vecs[15];

  // Reference model state. The receiver inputs are kept as a short history
  // indexed by cycle number, so "SYNC cycles ago" is simple index arithmetic.
  int            cyc;
  logic          dh [8];
  logic [3:0]    eh [8];
  logic [6:0]    m_err;
  logic [2:0]    m_en;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          m_wr;
  logic [DW-1:0] m_din;
  logic          m_rd;
  logic          m_rxw;
  logic          m_irq;

  // Clears the model to its power-on state.
  task automatic modelReset();
    cyc = 16;
    for (int i = 0; i < 8; i++) begin
      dh[i] = 1'b0;
      eh[i] = 4'h0;
    end
    m_err = '0; m_en = '0; m_rvalid = 0; m_rdata = '0;
    m_wr = 0; m_din = '0; m_rd = 0; m_rxw = 0; m_irq = 0;
  endtask

  // Advances the model by one clock edge, using the inputs present at that edge.
  task automatic modelStep();
    logic       evt;
    logic [6:0] set_bits;
    logic [6:0] clr_bits;
    logic [6:0] err_old;
    logic       rd;
    logic       wr;
    cyc++;
    dh[cyc % 8] = rx_done;
    eh[cyc % 8] = {overflow_error, break_error, stop_error, parity_error};
    // A frame is counted when rx_done, as it was SYNC cycles back, is high
    // and it was low the cycle before that.
    evt      = dh[(cyc - SYNC) % 8] & ~dh[(cyc - SYNC - 1) % 8];
    rd       = bus_sel & ~bus_write;
    wr       = bus_sel & bus_write;
    err_old  = m_err;
    set_bits = '0;
    clr_bits = '0;
    if (evt) begin
      set_bits[3:0] = eh[(cyc - SYNC) % 8];
      if (rx_full) set_bits[6] = 1'b1;
    end
    m_rxw    = evt & ~rx_full;
    m_rvalid = rd;
    m_rd     = rd && bus_addr == 2'd0 && !rx_empty;
    m_wr     = wr && bus_addr == 2'd0 && !tx_full;
    if (m_wr) m_din = bus_wdata;
    if (wr && bus_addr == 2'd0 && tx_full) set_bits[4] = 1'b1;
    if (rd && bus_addr == 2'd0 && rx_empty) set_bits[5] = 1'b1;
    if (rd) begin
      if (bus_addr == 2'd0)      m_rdata = rx_empty ? '0 : bus_data_out;
      else if (bus_addr == 2'd1) m_rdata = {4'h0, rx_full, rx_empty, tx_full, tx_empty};
      else if (bus_addr == 2'd2) m_rdata = {1'b0, err_old};
      else                       m_rdata = {5'h0, m_en};
    end
    if (wr && bus_addr == 2'd2) clr_bits = bus_wdata[6:0];
    m_irq = (m_en[0] && !rx_empty) || (m_en[1] && tx_empty) || (m_en[2] && err_old != 0);
    m_err = (err_old & ~clr_bits) | set_bits;
    if (wr && bus_addr == 2'd3) m_en = bus_wdata[2:0];
  endtask

  // Every clock advance goes through here so the model sees each edge.
  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one table row as a single-cycle access, then checks the row's
  // expected outputs.
  task automatic applyStimulus(input vec_t v, input int idx);
    bus_sel = v.sel; bus_write = v.write; bus_addr = v.addr; bus_wdata = v.wdata;
    {rx_full, rx_empty, tx_full, tx_empty} = v.stat;
    bus_data_out = v.dout;
    tick();
    bus_sel = 1'b0;
    checkOutput($sformatf("vec%0d rvalid", idx), 32'(bus_rvalid), 32'(v.exp_rvalid));
    checkOutput($sformatf("vec%0d rdata", idx), 32'(bus_rdata), 32'(v.exp_rdata));
    checkOutput($sformatf("vec%0d write_data", idx), 32'(write_data), 32'(v.exp_wr));
    checkOutput($sformatf("vec%0d bus_data_in", idx), 32'(bus_data_in), 32'(v.exp_din));
    checkOutput($sformatf("vec%0d read_data", idx), 32'(read_data), 32'(v.exp_rd));
  endtask

  task automatic busAccess(input logic wr, input logic [1:0] a, input logic [DW-1:0] d);
    bus_sel = 1'b1; bus_write = wr; bus_addr = a; bus_wdata = d;
    tick();
    bus_sel = 1'b0; bus_write = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    bus_sel = 0; bus_write = 0; bus_addr = 0; bus_wdata = 0; bus_data_out = 0;
    tx_full = 0; tx_empty = 1; rx_full = 0; rx_empty = 1; rx_done = 0;
    parity_error = 0; stop_error = 0; break_error = 0; overflow_error = 0;
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  // Counts rx_fifo_write pulses over a window and remembers when the first one
  // appeared, counted in cycles from the start of the window.
  task automatic countFrames(input int window, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= window; i++) begin
      tick();
      if (rx_fifo_write) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int pulses;
    int first;
    checks = 0;
    errors = 0;

    // Reset state, sampled while reset is still asserted.
    reset_n = 1'b0;
    bus_sel = 0; bus_write = 0; bus_addr = 0; bus_wdata = 0; bus_data_out = 0;
    tx_full = 0; tx_empty = 1; rx_full = 0; rx_empty = 1; rx_done = 0;
    parity_error = 0; stop_error = 0; break_error = 0; overflow_error = 0;
    #23;
    checkOutput("reset rvalid", 32'(bus_rvalid), 0);
    checkOutput("reset rdata", 32'(bus_rdata), 0);
    checkOutput("reset write_data", 32'(write_data), 0);
    checkOutput("reset bus_data_in", 32'(bus_data_in), 0);
    checkOutput("reset read_data", 32'(read_data), 0);
    checkOutput("reset rx_fifo_write", 32'(rx_fifo_write), 0);
    checkOutput("reset irq", 32'(irq), 0);

    // Table rows. stat is {rx_full, rx_empty, tx_full, tx_empty}.
    vecs[0]  = '{1, 1, 2'd0, 8'hA5, 4'b0001, 8'h00, 0, 8'h00, 1, 8'hA5, 0};
    vecs[1]  = '{1, 0, 2'd1, 8'h00, 4'b0101, 8'h00, 1, 8'h05, 0, 8'hA5, 0};
    vecs[2]  = '{1, 0, 2'd1, 8'h00, 4'b1010, 8'h00, 1, 8'h0A, 0, 8'hA5, 0};
    vecs[3]  = '{1, 0, 2'd0, 8'h00, 4'b0010, 8'h3C, 1, 8'h3C, 0, 8'hA5, 1};
    vecs[4]  = '{1, 0, 2'd3, 8'h00, 4'b0000, 8'h00, 1, 8'h00, 0, 8'hA5, 0};
    vecs[5]  = '{1, 1, 2'd3, 8'hFF, 4'b0000, 8'h00, 0, 8'h00, 0, 8'hA5, 0};
    vecs[6]  = '{1, 0, 2'd3, 8'h00, 4'b0000, 8'h00, 1, 8'h07, 0, 8'hA5, 0};
    vecs[7]  = '{1, 1, 2'd3, 8'h00, 4'b0000, 8'h00, 0, 8'h07, 0, 8'hA5, 0};
    vecs[8]  = '{1, 0, 2'd2, 8'h00, 4'b0000, 8'h00, 1, 8'h00, 0, 8'hA5, 0};
    vecs[9]  = '{0, 0, 2'd0, 8'h00, 4'b0000, 8'h00, 0, 8'h00, 0, 8'hA5, 0};
    vecs[10] = '{1, 1, 2'd1, 8'hFF, 4'b0000, 8'h00, 0, 8'h00, 0, 8'hA5, 0};
    vecs[11] = '{1, 0, 2'd1, 8'h00, 4'b1111, 8'h00, 1, 8'h0F, 0, 8'hA5, 0};
    vecs[12] = '{1, 1, 2'd0, 8'hC3, 4'b0100, 8'h00, 0, 8'h0F, 1, 8'hC3, 0};
    vecs[13] = '{1, 0, 2'd0, 8'h00, 4'b0100, 8'h77, 1, 8'h00, 0, 8'hC3, 0};
    vecs[14] = '{1, 0, 2'd2, 8'h00, 4'b0000, 8'h00, 1, 8'h20, 0, 8'hC3, 0};

    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    tick();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], i);
    end

    // TX overrun, then RX underrun, both visible in ERROR, then cleared by W1C.
    doReset();
    tx_full = 1'b1;
    busAccess(1'b1, 2'd0, 8'h5A);
    checkOutput("overrun no push", 32'(write_data), 0);
    tx_full = 1'b0;
    busAccess(1'b0, 2'd2, 8'h00);
    checkOutput("overrun error reg", 32'(bus_rdata), 32'h10);
    rx_empty = 1'b1;
    bus_data_out = 8'hEE;
    busAccess(1'b0, 2'd0, 8'h00);
    checkOutput("underrun rvalid", 32'(bus_rvalid), 1);
    checkOutput("underrun rdata", 32'(bus_rdata), 0);
    checkOutput("underrun no pop", 32'(read_data), 0);
    busAccess(1'b0, 2'd2, 8'h00);
    checkOutput("underrun error reg", 32'(bus_rdata), 32'h30);
    busAccess(1'b1, 2'd2, 8'h30);
    busAccess(1'b0, 2'd2, 8'h00);
    checkOutput("w1c clears all", 32'(bus_rdata), 0);
    tick();
    checkOutput("rvalid one cycle", 32'(bus_rvalid), 0);

    // A long rx_done level gives one frame with SYNC+1 cycles of latency, and
    // a second rise after a gap gives another one.
    rx_full = 1'b0;
    rx_done = 1'b1;
    countFrames(50, pulses, first);
    checkOutput("held level pulses", 32'(pulses), 1);
    checkOutput("frame latency", 32'(first), SYNC + 1);
    rx_done = 1'b0;
    tick();
    tick();
    rx_done = 1'b1;
    countFrames(10, pulses, first);
    checkOutput("second frame pulses", 32'(pulses), 1);
    checkOutput("second frame latency", 32'(first), SYNC + 1);

    // A frame that arrives while the RX FIFO is full is dropped but still
    // records its errors. W1C then clears one bit, and a clear that collides
    // with a new set loses to the set.
    doReset();
    rx_full = 1'b1;
    parity_error = 1'b1;
    stop_error = 1'b1;
    rx_done = 1'b1;
    countFrames(8, pulses, first);
    checkOutput("full fifo no write", 32'(pulses), 0);
    busAccess(1'b0, 2'd2, 8'h00);
    checkOutput("drop error reg", 32'(bus_rdata), 32'h43);
    busAccess(1'b1, 2'd2, 8'h01);
    busAccess(1'b0, 2'd2, 8'h00);
    checkOutput("w1c parity", 32'(bus_rdata), 32'h42);
    rx_full = 1'b0;
    rx_done = 1'b0;
    tick();
    tick();
    rx_done = 1'b1;
    tick();
    tick();
    busAccess(1'b1, 2'd2, 8'h01);
    checkOutput("collide frame write", 32'(rx_fifo_write), 1);
    busAccess(1'b0, 2'd2, 8'h00);
    checkOutput("set wins over clear", 32'(bus_rdata), 32'h43);

    // Interrupt sources.
    doReset();
    tx_empty = 1'b0;
    busAccess(1'b1, 2'd3, 8'h01);
    tick();
    checkOutput("irq rx empty", 32'(irq), 0);
    rx_empty = 1'b0;
    tick();
    checkOutput("irq rx not empty", 32'(irq), 1);
    rx_empty = 1'b1;
    tick();
    checkOutput("irq rx empty again", 32'(irq), 0);
    busAccess(1'b1, 2'd3, 8'h04);
    tick();
    checkOutput("irq no errors", 32'(irq), 0);
    tx_full = 1'b1;
    busAccess(1'b1, 2'd0, 8'h11);
    tx_full = 1'b0;
    tick();
    checkOutput("irq on overrun", 32'(irq), 1);

    // Reset asserted the cycle after a read access.
    doReset();
    rx_empty = 1'b0;
    busAccess(1'b1, 2'd3, 8'h01);
    tx_full = 1'b1;
    busAccess(1'b1, 2'd0, 8'h22);
    tx_full = 1'b0;
    checkOutput("pre-reset irq", 32'(irq), 1);
    bus_data_out = 8'h99;
    busAccess(1'b0, 2'd0, 8'h00);
    checkOutput("pre-reset read_data", 32'(read_data), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort rvalid", 32'(bus_rvalid), 0);
    checkOutput("abort read_data", 32'(read_data), 0);
    checkOutput("abort irq", 32'(irq), 0);
    checkOutput("abort rdata", 32'(bus_rdata), 0);
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("post-reset quiet %0d", i),
                  32'({bus_rvalid, read_data, write_data, rx_fifo_write}), 0);
    end
    busAccess(1'b0, 2'd2, 8'h00);
    checkOutput("post-reset error reg", 32'(bus_rdata), 0);
    busAccess(1'b0, 2'd3, 8'h00);
    checkOutput("post-reset irq_en", 32'(bus_rdata), 0);

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      bus_sel      = ($urandom_range(0, 2) != 0);
      bus_write    = $urandom_range(0, 1) == 1;
      bus_addr     = 2'($urandom_range(0, 3));
      bus_wdata    = 8'($urandom);
      bus_data_out = 8'($urandom);
      tx_full      = ($urandom_range(0, 3) == 0);
      tx_empty     = ($urandom_range(0, 2) == 0);
      rx_full      = ($urandom_range(0, 3) == 0);
      rx_empty     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) rx_done = ~rx_done;
      if ($urandom_range(0, 15) == 0) parity_error   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) stop_error     = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) break_error    = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) overflow_error = $urandom_range(0, 1) == 1;
      tick();
      checkOutput("rand rvalid", 32'(bus_rvalid), 32'(m_rvalid));
      checkOutput("rand rdata", 32'(bus_rdata), 32'(m_rdata));
      checkOutput("rand write_data", 32'(write_data), 32'(m_wr));
      checkOutput("rand bus_data_in", 32'(bus_data_in), 32'(m_din));
      checkOutput("rand read_data", 32'(read_data), 32'(m_rd));
      checkOutput("rand rx_fifo_write", 32'(rx_fifo_write), 32'(m_rxw));
      checkOutput("rand irq", 32'(irq), 32'(m_irq));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
